// File: rtl/w_pack.sv
// Write-side packer: collects 8/16/32-bit result beats into 32-bit words for the output buffer.
// The lane mode is locked on each word's first beat. A flush emits a partial word with a byte strobe.
module w_pack #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [2:0]        input_bitwidth,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [3:0]        out_strb,
  output logic              err
);

  localparam logic [2:0] MODE_32 = 3'b001;
  localparam logic [2:0] MODE_16 = 3'b010;
  localparam logic [2:0] MODE_8  = 3'b100;

  logic [DATA_W-1:0] acc;
  logic [1:0]        wr_ptr;
  logic [2:0]        mode_lk;
  logic              flush_pend;

  logic [2:0]        cur_mode;
  logic              legal;
  logic              out_busy;
  logic              accept;
  logic              complete;
  logic [DATA_W-1:0] beat_acc;
  logic [DATA_W-1:0] acc_after;
  logic [1:0]        ptr_after;
  logic [3:0]        part_strb;
  logic              flush_req;
  logic              load_full;
  logic              load_part;

  always_comb begin
    cur_mode  = (wr_ptr == 2'd0) ? input_bitwidth : mode_lk;
    legal     = (cur_mode == MODE_32) || (cur_mode == MODE_16) || (cur_mode == MODE_8);
    out_busy  = out_valid && !out_ready;
    in_ready  = !out_busy && legal;
    accept    = in_valid && in_ready;

    beat_acc  = acc;
    complete  = 1'b0;
    case (cur_mode)
      MODE_8: begin
        case (wr_ptr)
          2'd0:    beat_acc[7:0]   = data_in[7:0];
          2'd1:    beat_acc[15:8]  = data_in[7:0];
          2'd2:    beat_acc[23:16] = data_in[7:0];
          default: beat_acc[31:24] = data_in[7:0];
        endcase
        complete = (wr_ptr == 2'd3);
      end
      MODE_16: begin
        if (wr_ptr[0]) beat_acc[31:16] = data_in[15:0];
        else           beat_acc[15:0]  = data_in[15:0];
        complete = wr_ptr[0];
      end
      MODE_32: begin
        beat_acc = data_in;
        complete = 1'b1;
      end
      default: ;
    endcase

    ptr_after = accept ? wr_ptr + 2'd1 : wr_ptr;
    acc_after = accept ? beat_acc : acc;

    // Strobe for a partial word, from the number of beats held after this cycle's merge.
    part_strb = 4'b0000;
    case (cur_mode)
      MODE_8: begin
        case (ptr_after)
          2'd1:    part_strb = 4'b0001;
          2'd2:    part_strb = 4'b0011;
          2'd3:    part_strb = 4'b0111;
          default: part_strb = 4'b0000;
        endcase
      end
      MODE_16: part_strb = (ptr_after != 2'd0) ? 4'b0011 : 4'b0000;
      default: part_strb = 4'b0000;
    endcase

    flush_req = flush || flush_pend;
    load_full = accept && complete;
    load_part = !load_full && !out_busy && flush_req && (ptr_after != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      acc        <= '0;
      wr_ptr     <= 2'd0;
      mode_lk    <= 3'b000;
      flush_pend <= 1'b0;
      out_valid  <= 1'b0;
      data_out   <= '0;
      out_strb   <= 4'h0;
      err        <= 1'b0;
    end else begin
      if (in_valid && !legal) err <= 1'b1;
      if (out_busy) begin
        // Output register is occupied; remember one flush for when it frees up.
        if (flush) flush_pend <= 1'b1;
      end else begin
        flush_pend <= 1'b0;
        out_valid  <= load_full || load_part;
        if (accept && (wr_ptr == 2'd0)) mode_lk <= input_bitwidth;
        if (load_full) begin
          data_out <= beat_acc;
          out_strb <= 4'hF;
          acc      <= '0;
          wr_ptr   <= 2'd0;
        end else if (load_part) begin
          data_out <= acc_after;
          out_strb <= part_strb;
          acc      <= '0;
          wr_ptr   <= 2'd0;
        end else if (accept) begin
          acc    <= beat_acc;
          wr_ptr <= ptr_after;
        end
      end
    end
  end

endmodule
